// File: rtl/dw_seq_fxp_multifunc.sv
// Sequential sqrt / scaled reciprocal / bypass unit, one result bit per clock, valid/ready on both sides.
// Optional datapath gating input DG_ctrl is enabled by defining DW_SEQ_MULTIFUNC_DG_EN.
module dw_seq_fxp_multifunc #(
    parameter int width       = 16,
    parameter int func_select = 3
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DW_SEQ_MULTIFUNC_DG_EN
    input  logic             DG_ctrl,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] a,
    input  logic [1:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] z,
    output logic [7:0]       status
);
    localparam int RW = width + 2;
    localparam int CW = $clog2(width);
    localparam logic [1:0] FS = func_select[1:0];

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic            is_sqrt;
    logic [CW-1:0]   cnt;
    logic [width-1:0] work;   // sqrt: operand shifter; recip: dividend/quotient shifter
    logic [width-1:0] dvs;
    logic [width-1:0] root;
    logic [RW-1:0]   rem;
    logic            en;
    logic            illegal;

    logic [RW-1:0]    sq_rem, sq_trial, dv_rem, next_rem;
    logic [width-1:0] next_work, next_root, result;
    logic             sq_ge, dv_ge;

`ifdef DW_SEQ_MULTIFUNC_DG_EN
    assign en = DG_ctrl;
`else
    assign en = 1'b1;
`endif

    assign in_ready  = (state == IDLE) && en;
    assign out_valid = (state == DONE);
    assign illegal   = (func == 2'b11) || (func == 2'b00 && !FS[0]) || (func == 2'b01 && !FS[1]);

    always_comb begin
        // Shift the next operand pair (sqrt) or dividend bit (recip) into the remainder.
        sq_rem   = (rem << 2) | RW'(work[width-1 -: 2]);
        sq_trial = {root, 2'b01};
        sq_ge    = sq_rem >= sq_trial;
        dv_rem   = (rem << 1) | RW'(work[width-1]);
        dv_ge    = dv_rem >= {2'b00, dvs};
        next_rem  = '0;
        next_work = '0;
        next_root = root;
        if (is_sqrt) begin
            next_rem  = sq_ge ? sq_rem - sq_trial : sq_rem;
            next_work = work << 2;
            next_root = {root[width-2:0], sq_ge};
        end else begin
            next_rem  = dv_ge ? dv_rem - {2'b00, dvs} : dv_rem;
            next_work = {work[width-2:0], dv_ge};
        end
        result = is_sqrt ? next_root : next_work;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            is_sqrt <= 1'b0;
            cnt     <= '0;
            work    <= '0;
            dvs     <= '0;
            root    <= '0;
            rem     <= '0;
            z       <= '0;
            status  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid && en) begin
                    if (illegal) begin
                        z      <= '0;
                        status <= 8'h01;
                        state  <= DONE;
                    end else if (func == 2'b10) begin
                        z      <= a;
                        status <= {4'h0, (a == '0), 3'b000};
                        state  <= DONE;
                    end else if (func == 2'b01 && a == '0) begin
                        z      <= '1;
                        status <= 8'h02;
                        state  <= DONE;
                    end else begin
                        is_sqrt <= (func == 2'b00);
                        cnt     <= (func == 2'b00) ? CW'(width/2 - 1) : CW'(width - 1);
                        work    <= (func == 2'b00) ? a : '1;
                        dvs     <= a;
                        root    <= '0;
                        rem     <= '0;
                        state   <= CALC;
                    end
                end
                CALC: if (en) begin
                    work <= next_work;
                    root <= next_root;
                    rem  <= next_rem;
                    cnt  <= cnt - CW'(1);
                    if (cnt == '0) begin
                        z      <= result;
                        status <= {4'h0, (result == '0), (next_rem != '0), 2'b00};
                        state  <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dw_seq_fxp_multifunc.md
Name: dw_seq_fxp_multifunc

Overview:
- Sequential, handshaked multi-function unit: the next generation of the team's single-shot multifunction wrapper.
- Computes integer square root, scaled reciprocal, or bypass of a `width`-bit unsigned operand using radix-2 digit recurrence: one result bit per clock.
- Sits between a valid/ready producer and consumer in the arithmetic datapath.
- Status byte format follows the DW convention, with optional datapath gating.

Parameters:
- width, 16, operand/result width; must be even and >= 4.
- func_select, 3, enable mask: bit0 = sqrt, bit1 = recip. A function whose bit is 0 is treated as illegal. Bypass is always enabled.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  unit can accept
- a  input  width  unsigned operand
- func  input  2  00 sqrt, 01 recip, 10 bypass, 11 illegal
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts
- z  output  width  result
- status  output  8  [0] invalid (illegal func), [1] divide-by-zero, [2] inexact, [3] zero result, [7:4] 0

Behaviour:
- Clocking/reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1 (unless gated, see Optional Feature), out_valid=0, z=0, status=0, iteration counter=0.
- Reset mid-calculation or mid-DONE aborts the operation. No result is ever presented for it.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge k: capture a and func.
  - sqrt, or recip with a!=0: go to CALC with counter=N-1. N = width/2 for sqrt, width for recip.
  - bypass, illegal func, or recip with a==0: go directly to DONE. out_valid=1 from edge k+1.
- CALC:
  - in_ready=0; one recurrence step per cycle; counter decrements.
  - On the step with counter==0, go to DONE.
  - out_valid=1 from edge k+N+1.
  - a and func are ignored while in CALC.
- DONE:
  - out_valid=1; z and status held stable until out_ready=1.
  - On out_valid&out_ready: go to IDLE and drop out_valid.
  - No overlap: a new operand is accepted only in IDLE, so it cannot be accepted in the same cycle the result is taken.
- Arithmetic:
  - sqrt: z = floor(sqrt(a)), zero-extended to width.
  - sqrt inexact when the final remainder != 0 (a is not a perfect square).
  - recip: z = floor((2^width - 1)/a); restoring division, width iterations.
  - recip inexact when the remainder != 0.
  - recip a==0: z = all ones, status[1]=1.
  - bypass: z = a.
  - illegal (func==11, or a function disabled by func_select): z=0, status[0]=1.
  - status[3] = (z==0) in all cases except illegal.
- All internal partial-remainder registers are width+2 bits. No overflow is possible within that width.

Optional Feature:
- Macro DW_SEQ_MULTIFUNC_DG_EN.
- Defined: adds input port DG_ctrl (1 bit, placed after rst).
  - DG_ctrl=0: in_ready forced 0, and the operand and partial-remainder registers hold their values (no toggling).
  - An operation already in CALC freezes while DG_ctrl=0 and resumes on DG_ctrl=1. Latency grows by the number of gated cycles.
  - DONE output stays presented, and can still be taken, while gated.
- Undefined: no DG_ctrl port; the block is always enabled.

Test Plan (width=16, func_select=3):
- Reset, then sqrt a=144 accepted at edge 0 -> out_valid at edge 9, z=12, status=0x00.
- sqrt a=65535 -> z=255, status=0x04. Hold out_ready=0 for 5 cycles -> z/status stable, in_ready=0 throughout.
- recip a=3 -> out_valid at edge 17, z=21845, status=0x00. recip a=7 -> z=9362, status=0x04.
- recip a=0 -> out_valid at edge 1, z=0xFFFF, status=0x02. func=11 -> z=0, status=0x01. func_select=1 with recip -> status=0x01.
- Assert rst during CALC of sqrt a=400 -> next cycle out_valid=0 and in_ready=1. Then bypass a=0 -> z=0, status=0x08.
- With DW_SEQ_MULTIFUNC_DG_EN: DG_ctrl=0 for 3 cycles mid-sqrt of a=144 -> out_valid at edge 12, z=12.
